pmem_arbiter: RTL
=================

// Module: pmem_arbiter
// PURPOSE
//  Shares the single burst physical-memory port of mp4 between the icache and dcache line interfaces.
//  - Arbitrates whole-line transactions.
//  - Serialises each 256-bit line into 64-bit beats for the burst port.
//  - Returns one-cycle line responses to the granted cache.
//  - Sits between the caches and the pmem_* pins of the mp4 top level.
// PARAMETERS
//  ADDR_W  32   address width, byte address
//  LINE_W  256  cache line width in bits
//  BEAT_W  64   burst beat width; BEATS = LINE_W/BEAT_W = 4
// PORTS
//  clk           in   1       clock; all state updates on rising edge
//  rst_n         in   1       asynchronous reset, active-low
//  i_read        in   1       icache line read request
//  i_addr        in   ADDR_W  icache line address
//  i_rdata       out  LINE_W  icache line data; valid while i_resp=1
//  i_resp        out  1       icache transaction complete
//  d_read        in   1       dcache line read request
//  d_write       in   1       dcache line write request (writeback)
//  d_addr        in   ADDR_W  dcache line address
//  d_wdata       in   LINE_W  dcache writeback line
//  d_rdata       out  LINE_W  dcache line data; valid while d_resp=1
//  d_resp        out  1       dcache transaction complete
//  pmem_address  out  ADDR_W  burst address, line aligned
//  pmem_read     out  1       burst read command
//  pmem_write    out  1       burst write command
//  pmem_wdata    out  BEAT_W  current write beat
//  pmem_rdata    in   BEAT_W  current read beat
//  mem_resp      in   1       beat accepted/valid; one pulse per beat, BEATS beats per burst
// BEHAVIOUR
//  Reset: asynchronous on rst_n=0.
//   - State returns to IDLE; beat_cnt=0; last_grant=ICACHE.
//   - All outputs are 0, including the rdata line buffers.
//   - Reset mid-burst abandons the transaction; no resp is issued.
//  States and transitions:
//   - IDLE -> XFER: when any request is high.
//     - Sample the requests, pick the winner, latch {addr & ~(LINE_W/8-1), wdata, op}.
//     - Set beat_cnt=0.
//   - XFER:
//     - pmem_read/pmem_write are registered outputs and rise the cycle after the grant.
//     - They stay high, with pmem_address stable, until the last beat.
//     - On each mem_resp=1:
//       - Read: capture pmem_rdata into line[beat_cnt*64 +: 64]; beat 0 = bits 63:0.
//       - Write: advance pmem_wdata to the next 64-bit slice of the latched line.
//       - Increment beat_cnt.
//     - When mem_resp=1 and beat_cnt=BEATS-1: pmem_read/pmem_write drop next cycle; go to DONE.
//   - DONE:
//     - Pulse the winner's resp for exactly 1 cycle.
//     - The winner's rdata holds the assembled line and stays stable until that cache's next grant.
//     - Then go to IDLE.
//     - Requests are re-sampled only in IDLE, so there is at least 1 idle cycle between bursts.
//  Latency: with zero-wait memory, request at cycle 0 gives:
//   - pmem cmd at cycle 1.
//   - beats at cycles 1-4.
//   - resp at cycle 6.
//  Arbitration (default):
//   - Fixed priority, dcache over icache.
//   - last_grant updates on every grant.
//  Boundary conditions:
//   - d_read=d_write=1 simultaneously: treated as a write.
//   - Request deasserted mid-burst: ignored; the burst completes and resp still pulses.
//   - mem_resp while in IDLE or DONE: ignored; no state change.
//   - Beat counter wraps from BEATS-1 to 0 on the final beat.
//   - The losing request is held by its cache and wins in the next IDLE, subject to priority.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN:
//   - Defined: on simultaneous i/d requests, grant the cache NOT equal to last_grant.
//     Since last_grant resets to ICACHE, the first conflict after reset still grants dcache.
//   - Undefined: fixed dcache priority; last_grant is still tracked but unused.
// TESTING
//  1. Single icache read, addr 0x0000_0064, beats 0x11..,0x22..,0x33..,0x44.. with zero wait ->
//     pmem_address=0x0000_0060, pmem_read high cycles 1-4, i_resp=1 at cycle 6,
//     i_rdata={0x44..,0x33..,0x22..,0x11..}.
//  2. dcache write, addr 0x100, d_wdata=256'hD..C..B..A (beat slices) ->
//     pmem_wdata=A,B,C,D on successive mem_resp; pmem_write drops after beat 3; d_resp 1 cycle.
//  3. i_read and d_read rise together, held until resp ->
//     dcache served first, then icache; i_resp never coincides with d_resp.
//  4. With ARB_ROUND_ROBIN_EN: three back-to-back simultaneous requests -> grants D, I, D.
//     Without the macro: the dcache wins every time its request is present.
//  5. rst_n pulled low after the 2nd beat of a read ->
//     outputs 0 immediately, no resp; after release, a fresh request completes normally.
//  6. mem_resp with 3 wait cycles between beats, and a spurious mem_resp in IDLE ->
//     correct line assembled; the spurious pulse causes no grant or resp.

Source files
------------

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares the burst pmem port between icache and dcache line interfaces.
// Optional macro ARB_ROUND_ROBIN_EN alternates the grant on simultaneous requests.
module pmem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256,
    parameter int unsigned BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic [ADDR_W-1:0] pmem_address,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [BEAT_W-1:0] pmem_wdata,
    input  logic [BEAT_W-1:0] pmem_rdata,
    input  logic              mem_resp
);
    localparam int unsigned BEATS = LINE_W / BEAT_W;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_W / 8 - 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;
    typedef enum logic {ICACHE, DCACHE} src_t;

    state_t              state_q, state_d;
    src_t                grant_q, grant_d;
    src_t                last_grant_q, last_grant_d;
    src_t                win;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   wline_q, wline_d;
    logic [LINE_W-1:0]   i_line_q, i_line_d;
    logic [LINE_W-1:0]   d_line_q, d_line_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic                i_resp_q, i_resp_d;
    logic                d_resp_q, d_resp_d;
    logic                i_req, d_req;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    always_comb begin
        win = d_req ? DCACHE : ICACHE;
`ifdef ARB_ROUND_ROBIN_EN
        if (i_req && d_req) begin
            win = (last_grant_q == ICACHE) ? DCACHE : ICACHE;
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wline_d      = wline_q;
        i_line_d     = i_line_q;
        d_line_d     = d_line_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        i_resp_d     = 1'b0;
        d_resp_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // The resp cycle is spent in IDLE without granting, so the just-served
                // cache has time to drop its request before requests are sampled again.
                if ((i_req || d_req) && !i_resp_q && !d_resp_q) begin
                    state_d      = S_XFER;
                    grant_d      = win;
                    last_grant_d = win;
                    beat_cnt_d   = '0;
                    if (win == DCACHE) begin
                        addr_d  = d_addr & ~LINE_MASK;
                        write_d = d_write;
                        wline_d = d_wdata;
                    end else begin
                        addr_d  = i_addr & ~LINE_MASK;
                        write_d = 1'b0;
                        wline_d = '0;
                    end
                    rd_d = ~write_d;
                    wr_d = write_d;
                end
            end
            S_XFER: begin
                if (mem_resp) begin
                    if (!write_q) begin
                        if (grant_q == DCACHE) begin
                            d_line_d[beat_cnt_q * BEAT_W +: BEAT_W] = pmem_rdata;
                        end else begin
                            i_line_d[beat_cnt_q * BEAT_W +: BEAT_W] = pmem_rdata;
                        end
                    end
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = '0;
                        rd_d       = 1'b0;
                        wr_d       = 1'b0;
                        state_d    = S_DONE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                i_resp_d = (grant_q == ICACHE);
                d_resp_d = (grant_q == DCACHE);
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            grant_q      <= ICACHE;
            last_grant_q <= ICACHE;
            beat_cnt_q   <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wline_q      <= '0;
            i_line_q     <= '0;
            d_line_q     <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            i_resp_q     <= 1'b0;
            d_resp_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wline_q      <= wline_d;
            i_line_q     <= i_line_d;
            d_line_q     <= d_line_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            i_resp_q     <= i_resp_d;
            d_resp_q     <= d_resp_d;
        end
    end

    assign i_rdata      = i_line_q;
    assign d_rdata      = d_line_q;
    assign i_resp       = i_resp_q;
    assign d_resp       = d_resp_q;
    assign pmem_address = addr_q;
    assign pmem_read    = rd_q;
    assign pmem_write   = wr_q;
    assign pmem_wdata   = wline_q[beat_cnt_q * BEAT_W +: BEAT_W];
endmodule
